// File: rtl/ej32_mem_arb.sv
// Byte-port sequencer for eJ32: arbitrates fetch vs. load/store and serializes
// data accesses big-endian over the single 8-bit memory port.
module ej32_mem_arb #(
  parameter int ASZ = 17
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           if_req,
  input  logic [ASZ-1:0] if_addr,
  output logic           if_ack,
  output logic [7:0]     if_data,
  input  logic           d_req,
  input  logic           d_we,
  input  logic [1:0]     d_sz,
  input  logic           d_signed,
  input  logic [ASZ-1:0] d_addr,
  input  logic [31:0]    d_wdata,
  output logic           d_ack,
  output logic [31:0]    d_rdata,
  output logic           m_we,
  output logic [ASZ-1:0] m_ai,
  output logic [7:0]     m_vi,
  input  logic [7:0]     m_vo,
  output logic           busy,
  output logic [1:0]     state_dbg
);
  // Handshake: a requester raises req with stable inputs and holds them until
  // its one-cycle ack; the arbiter latches everything at the grant edge.
  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, ACK = 2'd3} state_t;

  localparam logic [ASZ-1:0] AI_ONE = ASZ'(1);

  state_t         state, state_n;
  logic           own_d, own_d_n;    // 1: data unit owns the transaction
  logic           last_d, last_d_n;  // 1: data was granted last
  logic [2:0]     n_r, n_n;
  logic           sgn_r, sgn_n;
  logic [2:0]     cnt, cnt_n;
  logic [23:0]    acc, acc_n;
  logic [31:0]    wbuf, wbuf_n;
  logic           m_we_n, if_ack_n, d_ack_n;
  logic [ASZ-1:0] m_ai_n;
  logic [7:0]     m_vi_n, if_data_n;
  logic [31:0]    d_rdata_n;
  logic           gnt_d, gnt_f;
  logic [2:0]     d_len;
  logic [31:0]    d_wal, rd_word, rd_ext;

  assign state_dbg = state;

  always_comb begin
    state_n   = state;
    own_d_n   = own_d;
    last_d_n  = last_d;
    n_n       = n_r;
    sgn_n     = sgn_r;
    cnt_n     = cnt;
    acc_n     = acc;
    wbuf_n    = wbuf;
    m_we_n    = 1'b0;
    m_ai_n    = m_ai;
    m_vi_n    = m_vi;
    if_ack_n  = 1'b0;
    d_ack_n   = 1'b0;
    if_data_n = if_data;
    d_rdata_n = d_rdata;

    case (d_sz)
      2'd0:    begin d_len = 3'd1; d_wal = {d_wdata[7:0], 24'h0};  end
      2'd1:    begin d_len = 3'd2; d_wal = {d_wdata[15:0], 16'h0}; end
      default: begin d_len = 3'd4; d_wal = d_wdata;                end
    endcase

    gnt_d = d_req & (~if_req | ~last_d);
    gnt_f = if_req & (~d_req | last_d);

    rd_word = {acc, m_vo};
    case (n_r)
      3'd1:    rd_ext = {{24{sgn_r & rd_word[7]}}, rd_word[7:0]};
      3'd2:    rd_ext = {{16{sgn_r & rd_word[15]}}, rd_word[15:0]};
      default: rd_ext = rd_word;
    endcase

    case (state)
      IDLE: begin
        if (gnt_d) begin
          own_d_n  = 1'b1;
          last_d_n = 1'b1;
          n_n      = d_len;
          sgn_n    = d_signed;
          cnt_n    = 3'd1;
          acc_n    = 24'h0;
          m_ai_n   = d_addr;
          if (d_we) begin
            state_n = WR;
            m_we_n  = 1'b1;
            m_vi_n  = d_wal[31:24];
            wbuf_n  = {d_wal[23:0], 8'h0};
          end else begin
            state_n = RD;
          end
        end else if (gnt_f) begin
          own_d_n  = 1'b0;
          last_d_n = 1'b0;
          n_n      = 3'd1;
          sgn_n    = 1'b0;
          cnt_n    = 3'd1;
          acc_n    = 24'h0;
          m_ai_n   = if_addr;
          state_n  = RD;
        end
      end
      RD: begin
        // cnt counts addresses issued; cnt = n+1 is the capture-only cycle
        if (cnt >= 3'd2) acc_n = rd_word[23:0];
        if (cnt < n_r) m_ai_n = m_ai + AI_ONE;
        cnt_n = cnt + 3'd1;
        if (cnt == n_r + 3'd1) begin
          state_n = ACK;
          if (own_d) begin
            d_ack_n   = 1'b1;
            d_rdata_n = rd_ext;
          end else begin
            if_ack_n  = 1'b1;
            if_data_n = m_vo;
          end
        end
      end
      WR: begin
        if (cnt < n_r) begin
          m_we_n = 1'b1;
          m_ai_n = m_ai + AI_ONE;
          m_vi_n = wbuf[31:24];
          wbuf_n = {wbuf[23:0], 8'h0};
          cnt_n  = cnt + 3'd1;
        end else begin
          state_n = ACK;
          d_ack_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      own_d   <= 1'b0;
      last_d  <= 1'b0;
      n_r     <= 3'd0;
      sgn_r   <= 1'b0;
      cnt     <= 3'd0;
      acc     <= 24'h0;
      wbuf    <= 32'h0;
      m_we    <= 1'b0;
      m_ai    <= '0;
      m_vi    <= 8'h0;
      if_ack  <= 1'b0;
      d_ack   <= 1'b0;
      if_data <= 8'h0;
      d_rdata <= 32'h0;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      own_d   <= own_d_n;
      last_d  <= last_d_n;
      n_r     <= n_n;
      sgn_r   <= sgn_n;
      cnt     <= cnt_n;
      acc     <= acc_n;
      wbuf    <= wbuf_n;
      m_we    <= m_we_n;
      m_ai    <= m_ai_n;
      m_vi    <= m_vi_n;
      if_ack  <= if_ack_n;
      d_ack   <= d_ack_n;
      if_data <= if_data_n;
      d_rdata <= d_rdata_n;
      busy    <= (state_n != IDLE);
    end
  end
endmodule

// File: tb/tb_ej32_mem_arb.sv
// Directed bench for ej32_mem_arb: byte memory model, per-cycle port trace
// and hand-computed expectations for fetch, loads, stores, contention, wrap, reset.
module tb_ej32_mem_arb;
  localparam int ASZ = 17;

  logic           clk = 1'b0;
  logic           rst;
  logic           if_req, if_ack, d_req, d_we, d_signed, d_ack, m_we, busy;
  logic [ASZ-1:0] if_addr, d_addr, m_ai;
  logic [7:0]     if_data, m_vi, m_vo;
  logic [1:0]     d_sz, state_dbg;
  logic [31:0]    d_wdata, d_rdata;

  ej32_mem_arb #(.ASZ(ASZ)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_data(if_data),
    .d_req(d_req), .d_we(d_we), .d_sz(d_sz), .d_signed(d_signed),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
    .m_we(m_we), .m_ai(m_ai), .m_vi(m_vi), .m_vo(m_vo),
    .busy(busy), .state_dbg(state_dbg)
  );

  // ---------------- clock / memory model ----------------
  always #5 clk = ~clk;

  logic [7:0]     mem [0:(1<<ASZ)-1];
  logic           pre_we = 1'b0;
  logic [ASZ-1:0] pre_addr = '0;
  logic [7:0]     pre_data = 8'h0;

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (m_we) mem[m_ai] <= m_vi;
    m_vo <= mem[m_ai];
  end

  // ---------------- scoreboard ----------------
  int          n_chk = 0;
  int          n_fail = 0;
  logic [32:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  int overlap = 0;
  always @(negedge clk) if (if_ack && d_ack) overlap++;

  // ---------------- driver tasks ----------------
  logic [ASZ-1:0] ai_tr [0:15];
  logic           we_tr [0:15];
  logic [7:0]     vi_tr [0:15];
  logic           busy_tr [0:15];
  int             ack_cyc;
  logic           got_if, got_d;

  task automatic preload(input logic [ASZ-1:0] a, input logic [7:0] v);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = v;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Cycle 0 is the IDLE cycle in which req is first seen; trace cycles 1.. until ack.
  task automatic do_xfer(input logic fetch, input logic we, input logic [1:0] sz,
                         input logic sgn, input logic [ASZ-1:0] addr, input logic [31:0] wd);
    @(posedge clk); #1;
    if (fetch) begin
      if_req = 1'b1; if_addr = addr;
    end else begin
      d_req = 1'b1; d_we = we; d_sz = sz; d_signed = sgn; d_addr = addr; d_wdata = wd;
    end
    ack_cyc = -1; got_if = 1'b0; got_d = 1'b0;
    @(negedge clk);
    busy_tr[0] = busy;
    for (int c = 1; c < 16 && ack_cyc < 0; c++) begin
      @(negedge clk);
      ai_tr[c] = m_ai; we_tr[c] = m_we; vi_tr[c] = m_vi; busy_tr[c] = busy;
      if (if_ack || d_ack) begin
        ack_cyc = c; got_if = if_ack; got_d = d_ack;
      end
    end
    if_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    chk("idle_after_ack", {60'h0, if_ack, d_ack, busy, m_we}, 64'h0);
  endtask

  // ---------------- test sequence ----------------
  logic [ASZ-1:0] pa [0:20];
  logic [7:0]     pv [0:20];
  int             got, rs_acks;
  logic [ASZ-1:0] ea;

  initial begin
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_sz = 2'd0;
    d_signed = 1'b0; d_addr = '0; d_wdata = 32'h0;

    pa[0]  = 17'h00010; pv[0]  = 8'hB6;
    pa[1]  = 17'h00100; pv[1]  = 8'h12;
    pa[2]  = 17'h00101; pv[2]  = 8'h34;
    pa[3]  = 17'h00102; pv[3]  = 8'h56;
    pa[4]  = 17'h00103; pv[4]  = 8'h78;
    pa[5]  = 17'h00020; pv[5]  = 8'hF0;
    pa[6]  = 17'h00030; pv[6]  = 8'h80;
    pa[7]  = 17'h00031; pv[7]  = 8'h01;
    pa[8]  = 17'h1FFFE; pv[8]  = 8'hA1;
    pa[9]  = 17'h1FFFF; pv[9]  = 8'hB2;
    pa[10] = 17'h00000; pv[10] = 8'hC3;
    pa[11] = 17'h00001; pv[11] = 8'hD4;
    for (int i = 0; i < 4; i++) begin
      pa[12+i] = 17'h00200 + ASZ'(i); pv[12+i] = 8'h00;
      pa[16+i] = 17'h00300 + ASZ'(i); pv[16+i] = 8'h00;
    end
    pa[20] = 17'h00212; pv[20] = 8'h00;
    for (int i = 0; i < 21; i++) preload(pa[i], pv[i]);
    preload(17'h00210, 8'h00);
    preload(17'h00211, 8'h00);

    // Reset values, with both requests already pending for the contention test
    if_addr = 17'h00010;
    d_we = 1'b0; d_sz = 2'd2; d_addr = 17'h00100;
    if_req = 1'b1; d_req = 1'b1;
    @(negedge clk);
    chk("rst_m_we", m_we, 0);
    chk("rst_m_ai", m_ai, 0);
    chk("rst_m_vi", m_vi, 0);
    chk("rst_acks", {if_ack, d_ack}, 0);
    chk("rst_if_data", if_data, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_state", state_dbg, 0);

    // Contention: data first after reset, then fetch, then data again
    exp_q.push_back({1'b1, 32'h12345678});
    exp_q.push_back({1'b0, 32'h000000B6});
    exp_q.push_back({1'b1, 32'h12345678});
    rst = 1'b0;
    got = 0;
    for (int c = 0; c < 80 && got < 3; c++) begin
      @(negedge clk);
      if (if_ack || d_ack) begin
        if (exp_q.size() == 0) chk("ct_extra_ack", 1, 0);
        else chk("ct_order", {d_ack, (d_ack ? d_rdata : {24'h0, if_data})}, exp_q.pop_front());
        got++;
        if (got == 3) begin
          if_req = 1'b0; d_req = 1'b0;
        end
      end
    end
    chk("ct_ack_count", got, 3);
    @(negedge clk);

    // Fetch only
    do_xfer(1'b1, 1'b0, 2'd0, 1'b0, 17'h00010, 32'h0);
    chk("f_ai1", ai_tr[1], 17'h00010);
    chk("f_ai2_hold", ai_tr[2], 17'h00010);
    chk("f_ack_cyc", ack_cyc, 3);
    chk("f_ack_owner", {got_if, got_d}, 2'b10);
    chk("f_data", if_data, 8'hB6);
    chk("f_busy", {busy_tr[0], busy_tr[1], busy_tr[2], busy_tr[3]}, 4'b0111);

    // Word load, then the reserved size alias
    do_xfer(1'b0, 1'b0, 2'd2, 1'b0, 17'h00100, 32'h0);
    for (int k = 1; k <= 4; k++) chk("wl_ai", ai_tr[k], 17'h00100 + ASZ'(k - 1));
    chk("wl_ai5_hold", ai_tr[5], 17'h00103);
    chk("wl_no_we", {we_tr[1], we_tr[2], we_tr[3], we_tr[4], we_tr[5]}, 0);
    chk("wl_ack_cyc", ack_cyc, 6);
    chk("wl_ack_owner", {got_if, got_d}, 2'b01);
    chk("wl_rdata", d_rdata, 32'h12345678);
    do_xfer(1'b0, 1'b0, 2'd3, 1'b0, 17'h00100, 32'h0);
    chk("wl3_ack_cyc", ack_cyc, 6);
    chk("wl3_rdata", d_rdata, 32'h12345678);

    // Byte and half loads with sign/zero extension
    do_xfer(1'b0, 1'b0, 2'd0, 1'b1, 17'h00020, 32'h0);
    chk("lb_s_ack_cyc", ack_cyc, 3);
    chk("lb_s_rdata", d_rdata, 32'hFFFFFFF0);
    do_xfer(1'b0, 1'b0, 2'd0, 1'b0, 17'h00020, 32'h0);
    chk("lb_u_rdata", d_rdata, 32'h000000F0);
    do_xfer(1'b0, 1'b0, 2'd1, 1'b1, 17'h00030, 32'h0);
    chk("lh_s_ack_cyc", ack_cyc, 4);
    chk("lh_s_rdata", d_rdata, 32'hFFFF8001);
    do_xfer(1'b0, 1'b0, 2'd1, 1'b0, 17'h00030, 32'h0);
    chk("lh_u_rdata", d_rdata, 32'h00008001);

    // Word store, MSB first
    do_xfer(1'b0, 1'b1, 2'd2, 1'b0, 17'h00200, 32'hCAFEBABE);
    for (int k = 1; k <= 4; k++) begin
      chk("sw_we", we_tr[k], 1);
      chk("sw_ai", ai_tr[k], 17'h00200 + ASZ'(k - 1));
    end
    chk("sw_vi", {vi_tr[1], vi_tr[2], vi_tr[3], vi_tr[4]}, 32'hCAFEBABE);
    chk("sw_ack_cyc", ack_cyc, 5);
    chk("sw_we_ack", we_tr[5], 0);
    chk("sw_mem", {mem[17'h200], mem[17'h201], mem[17'h202], mem[17'h203]}, 32'hCAFEBABE);
    chk("sw_rdata_held", d_rdata, 32'h00008001);

    // Half store uses only the low 16 bits of d_wdata
    do_xfer(1'b0, 1'b1, 2'd1, 1'b0, 17'h00210, 32'hFFFF1234);
    chk("sh_vi", {vi_tr[1], vi_tr[2]}, 16'h1234);
    chk("sh_ack_cyc", ack_cyc, 3);
    chk("sh_mem", {mem[17'h210], mem[17'h211], mem[17'h212]}, 24'h123400);

    // Word load wrapping past the top of the address space
    do_xfer(1'b0, 1'b0, 2'd2, 1'b0, 17'h1FFFE, 32'h0);
    for (int k = 1; k <= 4; k++) begin
      ea = 17'h1FFFE + ASZ'(k - 1);
      chk("wrap_ai", ai_tr[k], ea);
    end
    chk("wrap_rdata", d_rdata, 32'hA1B2C3D4);

    // Reset during a word store: only the first byte lands
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b1; d_sz = 2'd2; d_addr = 17'h00300; d_wdata = 32'hDEADBEEF;
    @(negedge clk);
    @(negedge clk);
    chk("rs_we_c1", {m_we, m_vi}, {1'b1, 8'hDE});
    rst = 1'b1; d_req = 1'b0;
    @(negedge clk);
    chk("rs_we_c2", m_we, 0);
    chk("rs_state", state_dbg, 0);
    chk("rs_busy", busy, 0);
    rst = 1'b0;
    rs_acks = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (d_ack || if_ack || m_we) rs_acks++;
    end
    chk("rs_quiet", rs_acks, 0);
    chk("rs_mem", {mem[17'h300], mem[17'h301], mem[17'h302], mem[17'h303]}, 32'hDE000000);

    chk("ack_overlap", overlap, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ej32_mem_arb.md
Name: ej32_mem_arb

Overview:
- Sequencer/arbiter sharing the single 8-bit byte memory port (mb8_io master side) between the instruction-fetch unit and the data (load/store) unit of eJ32.
- Fetch requests are single-byte reads.
- Data requests are byte/half/word reads or writes, serialized big-endian over the byte port.
- Owns all m_* strobes; no other block drives the byte memory.

Parameters:
ASZ, 17, byte address width (matches `IU`)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
if_req  in  1  fetch request, held until if_ack
if_addr  in  ASZ  fetch byte address
if_ack  out  1  one-cycle pulse: if_data valid
if_data  out  8  fetched byte, held until next fetch ack
d_req  in  1  data request, held until d_ack
d_we  in  1  1=store, 0=load
d_sz  in  2  0=byte, 1=half, 2=word, 3=word (reserved alias)
d_signed  in  1  load sign-extends byte/half when 1, zero-extends when 0
d_addr  in  ASZ  address of most-significant byte
d_wdata  in  32  store data, right-aligned
d_ack  out  1  one-cycle pulse: load data valid / store complete
d_rdata  out  32  load result, held until next load ack
m_we  out  1  byte memory write enable
m_ai  out  ASZ  byte memory address
m_vi  out  8  byte memory write data
m_vo  in  8  byte memory read data; carries mem[m_ai of previous cycle]
busy  out  1  high in every non-IDLE state

Behaviour:
- Clock is clk. Reset is synchronous, active-high, on rst.
- Reset values: state=IDLE; m_we, m_ai, m_vi, if_ack, d_ack, if_data, d_rdata, busy all 0; last_grant=FETCH, so data wins the first tie.
- All outputs are registered.
- States: IDLE, RD, WR, ACK.
- IDLE arbitration (evaluated each cycle):
  - Only one req high: grant it.
  - Both high: grant the one not granted last (round-robin); update last_grant on grant.
- At the grant edge, latch the following. Requester inputs are ignored until its ack.
  - Owner.
  - Address a.
  - Byte count N: fetch=1; data d_sz 0/1/2/3 -> 1/2/4/4.
  - d_we, d_signed.
  - Write data.
- Read sequence (fetch, or data with d_we=0):
  - Grant is in cycle 0.
  - Cycle k (1..N): m_ai=a+k-1, m_we=0.
  - Cycles 2..N+1: m_vo is shifted into a 32-bit accumulator, MSB first.
  - Cycle N+2: state ACK; owner ack=1; if_data or d_rdata updated.
  - Latency from req seen in cycle 0 to ack: N+2 cycles (fetch 3, word 6).
  - m_ai holds its last value during the capture-only cycle N+1.
- Write sequence:
  - Cycle k (1..N): m_we=1, m_ai=a+k-1, m_vi = byte (N-k) of d_wdata; byte 0 = LSB, so MSB is written first.
  - Cycle N+1: ACK, d_ack=1, m_we=0.
  - Latency N+1 cycles.
- ACK state always returns to IDLE. There is at least one IDLE cycle between transactions.
- Load extension:
  - Half: rdata = {16{s&b15}, half}.
  - Byte: {24{s&b7}, byte}.
  - Word: unmodified.
- Address arithmetic wraps modulo 2^ASZ, e.g. word at 2^ASZ-2 touches -2,-1,0,1.
- m_we is high only in WR cycles. m_vi is don't-care (hold last) otherwise.
- Requester lowering req before its ack is illegal. The latched transaction completes regardless.
- Non-owner req rising mid-transaction: the request waits; it is served at the next IDLE, subject to arbitration.
- A new req asserted in the ack cycle is seen in the following IDLE cycle.
- rst mid-transaction:
  - Next cycle is IDLE with m_we=0 and no ack.
  - Partially written bytes stay in memory.
  - No continuation or retry.
- Unowned ack never asserted. if_ack and d_ack are never high together.

Test Plan:
- Fetch only: if_req, if_addr=0x010, mem[0x010]=0xB6 -> m_ai=0x010 in cycle 1, if_ack in cycle 3, if_data=0xB6, busy high cycles 1-3.
- Word load: d_addr=0x100, mem=12 34 56 78, d_sz=2 -> m_ai 0x100..0x103 cycles 1-4, d_ack cycle 6, d_rdata=0x12345678.
- Signed loads: mem[0x20]=0xF0, byte d_signed=1 -> 0xFFFFFFF0; d_signed=0 -> 0x000000F0. Half mem=0x8001, signed -> 0xFFFF8001.
- Word store: d_wdata=0xCAFEBABE @0x200 -> m_we=1 cycles 1-4, m_vi CA,FE,BA,BE at 0x200..0x203, d_ack cycle 5, memory readback matches.
- Contention: if_req and d_req both high from reset -> data granted first, then fetch, then data again while both held. Acks alternate, never overlap.
- Wrap plus reset: word load at 0x1FFFE (ASZ=17) -> m_ai 1FFFE,1FFFF,00000,00001. Separately, rst in cycle 2 of a word store -> m_we=0 next cycle, state IDLE, no d_ack, only the first byte written.
